// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider / tick generator.
// Each channel counts to a double-buffered divisor and emits a 50%-duty
// divided clock plus a one-cycle tick on every terminal count.
// Optional feature macro: CLK_DIV_PHASE_EN (sync restarts every channel's phase).
module clk_div_multi #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned CNT_W   = 21,
    parameter int unsigned DEF_NUM = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*CNT_W-1:0] num,
    input  logic                 sync,
    output logic [NCH-1:0]       clock,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       busy
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_NUM);

    logic [CNT_W-1:0] count_q [NCH];
    logic [CNT_W-1:0] count_d [NCH];
    logic [CNT_W-1:0] div_q   [NCH];
    logic [CNT_W-1:0] div_d   [NCH];
    logic [NCH-1:0]   clock_q, clock_d;
    logic [NCH-1:0]   tick_q,  tick_d;
    logic [NCH-1:0]   busy_q,  busy_d;

`ifndef CLK_DIV_PHASE_EN
    // sync has no function in this build; sink it so the port stays in place
    logic unused_sync;
    assign unused_sync = sync;
`endif

    // Per-channel next state: terminal count reloads the shadow divisor
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            count_d[i] = count_q[i];
            div_d[i]   = div_q[i];
            clock_d[i] = clock_q[i];
            tick_d[i]  = 1'b0;
            busy_d[i]  = (num[i*CNT_W +: CNT_W] != div_q[i]);

            if (en[i]) begin
                if (count_q[i] == div_q[i]) begin
                    count_d[i] = '0;
                    clock_d[i] = ~clock_q[i];
                    tick_d[i]  = 1'b1;
                    div_d[i]   = num[i*CNT_W +: CNT_W];
                end else begin
                    count_d[i] = count_q[i] + CNT_W'(1);
                end
            end

`ifdef CLK_DIV_PHASE_EN
            // sync overrides everything, including a coincident terminal count
            if (sync) begin
                count_d[i] = '0;
                clock_d[i] = 1'b0;
                tick_d[i]  = 1'b0;
                div_d[i]   = num[i*CNT_W +: CNT_W];
            end
`endif
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= '0;
                div_q[i]   <= DEF_DIV;
            end
            clock_q <= '0;
            tick_q  <= '0;
            busy_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= count_d[i];
                div_q[i]   <= div_d[i];
            end
            clock_q <= clock_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    assign clock = clock_q;
    assign tick  = tick_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (NCH=2, CNT_W=4, DEF_NUM=0).
// Edge numbering: e1 is the first rising edge after reset release.
module tb_clk_div_multi;

    localparam int unsigned NCH   = 2;
    localparam int unsigned CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       en;
    logic [NCH*CNT_W-1:0] num;
    logic                 sync;
    logic [NCH-1:0]       clock;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       busy;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEF_NUM(0)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .num   (num),
        .sync  (sync),
        .clock (clock),
        .tick  (tick),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across two edges, release just after an edge
    task automatic do_reset(input logic [7:0] n, input logic [1:0] e);
        reset = 1'b1;
        num   = n;
        en    = e;
        sync  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // ch0 N=3, ch1 N=1; outputs zero during reset; ticks/clock cadence after
    task automatic test_reset();
        logic [1:0] exp_t, exp_c;
        reset = 1'b1; num = {4'd1, 4'd3}; en = 2'b11; sync = 1'b0;
        #1;
        n_tests++;
        if ({clock, tick, busy} !== 6'b0) begin
            $display("FAIL reset_async: got %b expected 000000", {clock, tick, busy});
            n_fail++;
        end
        step(); step();
        n_tests++;
        if ({clock, tick, busy} !== 6'b0) begin
            $display("FAIL reset_held: got %b expected 000000", {clock, tick, busy});
            n_fail++;
        end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_t = {(k % 2) == 1, (k % 4) == 1};
            exp_c = {((k - 1) / 2) % 2 == 0, ((k - 1) / 4) % 2 == 0};
            n_tests++;
            if (tick !== exp_t) begin
                $display("FAIL basic_tick e%0d: got %b expected %b", k, tick, exp_t);
                n_fail++;
            end
            n_tests++;
            if (clock !== exp_c) begin
                $display("FAIL basic_clock e%0d: got %b expected %b", k, clock, exp_c);
                n_fail++;
            end
            if (k == 1) begin
                n_tests++;
                if (busy !== 2'b11) begin
                    $display("FAIL basic_busy_e1: got %b expected 11", busy);
                    n_fail++;
                end
            end
            if (k == 2) begin
                n_tests++;
                if (busy !== 2'b00) begin
                    $display("FAIL basic_busy_e2: got %b expected 00", busy);
                    n_fail++;
                end
            end
        end
    endtask

    // ch0 3 -> 9 after e3: period ending e5 stays 4, then ticks at e15, e25
    task automatic test_div_change();
        logic exp;
        do_reset({4'd1, 4'd3}, 2'b11);
        step(); step(); step();
        num = {4'd1, 4'd9};
        step();
        n_tests++;
        if (busy[0] !== 1'b1 || tick[0] !== 1'b0) begin
            $display("FAIL chg_e4: got busy=%b tick=%b expected busy=1 tick=0", busy[0], tick[0]);
            n_fail++;
        end
        step();
        n_tests++;
        if (tick[0] !== 1'b1 || clock[0] !== 1'b0) begin
            $display("FAIL chg_e5: got tick=%b clock=%b expected tick=1 clock=0", tick[0], clock[0]);
            n_fail++;
        end
        for (int k = 6; k <= 25; k++) begin
            step();
            exp = (k == 15) || (k == 25);
            n_tests++;
            if (tick[0] !== exp) begin
                $display("FAIL chg_tick e%0d: got %b expected %b", k, tick[0], exp);
                n_fail++;
            end
            if (k == 6) begin
                n_tests++;
                if (busy[0] !== 1'b0) begin
                    $display("FAIL chg_busy_clear: got %b expected 0", busy[0]);
                    n_fail++;
                end
            end
            if (k == 14 || k == 15) begin
                n_tests++;
                if (clock[0] !== (k == 15)) begin
                    $display("FAIL chg_clock e%0d: got %b expected %b", k, clock[0], k == 15);
                    n_fail++;
                end
            end
        end
    endtask

    // N=0: tick held high, clock toggles every edge
    task automatic test_zero();
        do_reset({4'd1, 4'd0}, 2'b11);
        for (int k = 1; k <= 6; k++) begin
            step();
            n_tests++;
            if (tick[0] !== 1'b1 || clock[0] !== logic'(k % 2) || busy[0] !== 1'b0) begin
                $display("FAIL zero e%0d: got tick=%b clock=%b busy=%b expected tick=1 clock=%0d busy=0",
                         k, tick[0], clock[0], busy[0], k % 2);
                n_fail++;
            end
        end
    endtask

    // en[0] low for 5 edges at count=2 (N=3): hold, then tick 2 edges after re-enable
    task automatic test_enable();
        do_reset({4'd1, 4'd3}, 2'b11);
        step(); step(); step();
        en = 2'b10;
        for (int k = 4; k <= 8; k++) begin
            step();
            n_tests++;
            if (tick[0] !== 1'b0 || clock[0] !== 1'b1 || tick[1] !== logic'(k % 2)) begin
                $display("FAIL en_hold e%0d: got tick=%b clock0=%b expected tick=%0d0 clock0=1",
                         k, tick, clock[0], k % 2);
                n_fail++;
            end
        end
        en = 2'b11;
        step();
        n_tests++;
        if (tick[0] !== 1'b0) begin
            $display("FAIL en_resume_e9: got %b expected 0", tick[0]);
            n_fail++;
        end
        step();
        n_tests++;
        if (tick[0] !== 1'b1 || clock[0] !== 1'b0) begin
            $display("FAIL en_resume_e10: got tick=%b clock=%b expected tick=1 clock=0", tick[0], clock[0]);
            n_fail++;
        end
    endtask

    // Reset mid-period (N=9, count=5, clock=1) clears outputs without an edge
    task automatic test_async_reset();
        logic exp;
        do_reset({4'd1, 4'd9}, 2'b11);
        for (int k = 1; k <= 6; k++) step();
        n_tests++;
        if (clock[0] !== 1'b1) begin
            $display("FAIL areset_pre: got clock=%b expected 1", clock[0]);
            n_fail++;
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({clock, tick, busy} !== 6'b0) begin
            $display("FAIL areset_now: got %b expected 000000", {clock, tick, busy});
            n_fail++;
        end
        step();
        reset = 1'b0;
        // count=0 and div_act=DEF_NUM=0 after reset: tick at e1, reload 9, next at e11
        for (int k = 1; k <= 11; k++) begin
            step();
            exp = (k == 1) || (k == 11);
            n_tests++;
            if (tick[0] !== exp) begin
                $display("FAIL areset_after e%0d: got %b expected %b", k, tick[0], exp);
                n_fail++;
            end
        end
    endtask

    // num all-ones: period 16 edges between ticks
    task automatic test_all_ones();
        do_reset({4'd1, 4'd15}, 2'b11);
        step();
        for (int k = 2; k <= 17; k++) begin
            step();
            if (k >= 16) begin
                n_tests++;
                if (tick[0] !== (k == 17) || clock[0] !== (k == 16)) begin
                    $display("FAIL ones e%0d: got tick=%b clock=%b expected tick=%b clock=%b",
                             k, tick[0], clock[0], k == 17, k == 16);
                    n_fail++;
                end
            end
        end
    endtask

    // num={4,4}, ch1 started 2 edges late, sync pulse on e5
    task automatic test_sync();
        logic [1:0] exp;
        do_reset({4'd4, 4'd4}, 2'b01);
        step(); step();
        en = 2'b11;
        step(); step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 6; k <= 16; k++) begin
            step();
`ifdef CLK_DIV_PHASE_EN
            exp = {2{(k == 10) || (k == 15)}};
`else
            exp = {(k == 8) || (k == 13), (k == 6) || (k == 11) || (k == 16)};
`endif
            n_tests++;
            if (tick !== exp) begin
                $display("FAIL sync_tick e%0d: got %b expected %b", k, tick, exp);
                n_fail++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_div_change();
        test_zero();
        test_enable();
        test_async_reset();
        test_all_ones();
        test_sync();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
